// File: rtl/acc_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : acc_result_fifo
// Description : Captures tlast-marked accumulator sums into a small FIFO,
//               re-frames them on an AXI-Stream master and counts overflow drops.
// Revision    : 1.0 - initial release
// ============================================================================
module acc_result_fifo #(
  parameter int DATA_WIDTH       = 16,
  parameter int TUSER_WIDTH      = 4,
  parameter int FIFO_DEPTH       = 4,
  parameter int GROUPS_PER_FRAME = 3,
  parameter int DROP_CNT_WIDTH   = 8
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          aclken,
  input  logic                          s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tlast,
  input  logic [TUSER_WIDTH-1:0]        s_axis_tuser,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [TUSER_WIDTH-1:0]        m_axis_tuser,
  output logic                          m_axis_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          overflow,
  output logic [DROP_CNT_WIDTH-1:0]     drop_count
);

  localparam int c_PTR_W   = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W   = c_PTR_W + 1;
  localparam int c_FRM_W   = (GROUPS_PER_FRAME > 1) ? $clog2(GROUPS_PER_FRAME) : 1;
  localparam int c_ENTRY_W = TUSER_WIDTH + DATA_WIDTH;
  localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(FIFO_DEPTH);
  localparam logic [c_FRM_W-1:0] c_FRM_LAST = c_FRM_W'(GROUPS_PER_FRAME - 1);

  logic [c_ENTRY_W-1:0]      r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]        r_wr_ptr;
  logic [c_PTR_W-1:0]        r_rd_ptr;
  logic [c_CNT_W-1:0]        r_fill;
  logic [c_FRM_W-1:0]        r_frm_cnt;
  logic                      r_overflow;
  logic [DROP_CNT_WIDTH-1:0] r_drop_cnt;

  logic                      w_valid;
  logic                      w_cap;
  logic                      w_pop;
  logic                      w_push;
  logic                      w_drop;
  logic [c_ENTRY_W-1:0]      w_head;

  assign w_valid = (r_fill != '0);
  assign w_cap   = aclken & s_axis_tvalid & s_axis_tlast;
  assign w_pop   = aclken & w_valid & m_axis_tready;
  // A full FIFO still accepts a capture when the head leaves on the same edge.
  assign w_push  = w_cap & ((r_fill < c_DEPTH) | w_pop);
  assign w_drop  = w_cap & ~w_push;
  assign w_head  = r_mem[r_rd_ptr];

  // Storage carries no reset; stale entries are never visible because the
  // head is masked whenever the FIFO is empty.
  always_ff @(posedge aclk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {s_axis_tuser, s_axis_tdata};
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fill     <= '0;
      r_frm_cnt  <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + c_PTR_W'(1);
        r_frm_cnt <= (r_frm_cnt == c_FRM_LAST) ? '0 : r_frm_cnt + c_FRM_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + c_CNT_W'(1);
        2'b01:   r_fill <= r_fill - c_CNT_W'(1);
        default: r_fill <= r_fill;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != '1) begin
          r_drop_cnt <= r_drop_cnt + DROP_CNT_WIDTH'(1);
        end
      end
    end
  end

  assign m_axis_tvalid = w_valid;
  assign m_axis_tdata  = w_valid ? w_head[DATA_WIDTH-1:0] : '0;
  assign m_axis_tuser  = w_valid ? w_head[c_ENTRY_W-1:DATA_WIDTH] : '0;
  assign m_axis_tlast  = w_valid & (r_frm_cnt == c_FRM_LAST);
  assign fill_level    = r_fill;
  assign overflow      = r_overflow;
  assign drop_count    = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_acc_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_acc_result_fifo
// Description : Vector table plus scoreboard bench for acc_result_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_result_fifo;

  localparam int DW    = 16;
  localparam int UW    = 4;
  localparam int DEPTH = 4;
  localparam int GPF   = 3;
  localparam int DCW   = 8;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          aclken = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tlast = 1'b0;
  logic [UW-1:0] s_axis_tuser = '0;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tlast;
  logic [$clog2(DEPTH):0] fill_level;
  logic          overflow;
  logic [DCW-1:0] drop_count;

  acc_result_fifo #(
    .DATA_WIDTH(DW), .TUSER_WIDTH(UW), .FIFO_DEPTH(DEPTH),
    .GROUPS_PER_FRAME(GPF), .DROP_CNT_WIDTH(DCW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .aclken(aclken),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast), .fill_level(fill_level),
    .overflow(overflow), .drop_count(drop_count)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    bit            rst;
    bit            en;
    bit            vld;
    logic [DW-1:0] data;
    bit            last;
    logic [UW-1:0] user;
    bit            rdy;
    int            exp_fill;
  } vec_t;

  typedef struct {
    logic [DW-1:0] d;
    logic [UW-1:0] u;
  } ent_t;

  ent_t sb[$];
  int   m_frm = 0;
  bit   m_ovf = 1'b0;
  int   m_drops = 0;
  int   errors = 0;
  int   checks = 0;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the scoreboard state.
  task automatic model_check();
    check("tvalid", 32'(m_axis_tvalid), 32'(sb.size() != 0));
    check("fill_level", 32'(fill_level), 32'(sb.size()));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("drop_count", 32'(drop_count), 32'(m_drops));
    check("tlast", 32'(m_axis_tlast), 32'(sb.size() != 0 && m_frm == GPF - 1));
    if (sb.size() != 0) begin
      check("tdata", 32'(m_axis_tdata), 32'(sb[0].d));
      check("tuser", 32'(m_axis_tuser), 32'(sb[0].u));
    end else begin
      check("tdata_idle", 32'(m_axis_tdata), 32'd0);
    end
  endtask

  task automatic async_reset();
    aclken = 1'b1; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; m_axis_tready = 1'b0;
    aresetn = 1'b0;
    #1;
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_tdata", 32'(m_axis_tdata), 32'd0);
    check("rst_tuser", 32'(m_axis_tuser), 32'd0);
    check("rst_tlast", 32'(m_axis_tlast), 32'd0);
    check("rst_fill", 32'(fill_level), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    sb.delete();
    m_frm = 0; m_ovf = 1'b0; m_drops = 0;
    #3 aresetn = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    bit pop, cap, push;
    aclken = v.en; s_axis_tvalid = v.vld; s_axis_tdata = v.data;
    s_axis_tlast = v.last; s_axis_tuser = v.user; m_axis_tready = v.rdy;
    #1;
    model_check();
    pop  = v.en && sb.size() != 0 && v.rdy;
    cap  = v.en && v.vld && v.last;
    push = cap && (sb.size() < DEPTH || pop);
    if (pop) begin
      void'(sb.pop_front());
      m_frm = (m_frm == GPF - 1) ? 0 : m_frm + 1;
    end
    if (push) sb.push_back('{v.data, v.user});
    if (cap && !push) begin
      m_ovf = 1'b1;
      if (m_drops < 255) m_drops++;
    end
    @(posedge aclk);
    #1;
    if (v.exp_fill >= 0) check("fill_after", 32'(fill_level), 32'(v.exp_fill));
  endtask

  function automatic vec_t mk(bit en, bit vld, logic [DW-1:0] data, bit last,
                              logic [UW-1:0] user, bit rdy, int fill);
    vec_t v;
    v.rst = 1'b0; v.en = en; v.vld = vld; v.data = data; v.last = last;
    v.user = user; v.rdy = rdy; v.exp_fill = fill;
    return v;
  endfunction

  function automatic vec_t mk_rst();
    vec_t v = mk(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, -1);
    v.rst = 1'b1;
    return v;
  endfunction

  initial begin
    // Basic path: only the tlast beat is captured.
    tbl.push_back(mk(1, 1, 16'd15360, 0, 4'd0, 1, 0));
    tbl.push_back(mk(1, 1, 16'd16384, 0, 4'd0, 1, 0));
    tbl.push_back(mk(1, 1, 16'd17408, 1, 4'd5, 1, 1));
    tbl.push_back(mk(1, 0, 16'd0,     0, 4'd0, 1, 0));
    // Backpressure and framing.
    tbl.push_back(mk_rst());
    tbl.push_back(mk(1, 1, 16'd18432, 1, 4'd1, 0, 1));
    tbl.push_back(mk(1, 1, 16'd18944, 1, 4'd2, 0, 2));
    tbl.push_back(mk(1, 1, 16'd19328, 1, 4'd3, 0, 3));
    tbl.push_back(mk(1, 0, 16'd0,     0, 4'd0, 1, 2));
    tbl.push_back(mk(1, 0, 16'd0,     0, 4'd0, 1, 1));
    tbl.push_back(mk(1, 0, 16'd0,     0, 4'd0, 1, 0));
    // Overflow: six captures into a depth-4 FIFO.
    tbl.push_back(mk_rst());
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk(1, 1, 16'(16'h1000 + i), 1, 4'(i), 0, (i < 4) ? i + 1 : 4));
    // Full with simultaneous pop and capture, then drain.
    tbl.push_back(mk(1, 1, 16'h2000, 1, 4'd7, 1, 4));
    for (int i = 3; i >= 0; i--)
      tbl.push_back(mk(1, 0, 16'd0, 0, 4'd0, 1, i));
    // Clock enable: three captures, then frozen cycles with everything high.
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1, 1, 16'(16'hA001 + i), 1, 4'(8 + i), 0, i + 1));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 1, 16'hBEEF, 1, 4'hF, 1, 3));
    tbl.push_back(mk(1, 0, 16'd0, 0, 4'd0, 1, 2));
    tbl.push_back(mk(1, 0, 16'd0, 0, 4'd0, 1, 1));

    repeat (2) @(posedge aclk);
    #1;
    model_check();
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    foreach (tbl[i]) begin
      if (tbl[i].rst) async_reset();
      else apply(tbl[i]);
    end

    // Mid-frame asynchronous reset, then framing restarts at word 0.
    check("pre_rst_fill", 32'(fill_level), 32'd1);
    async_reset();
    for (int i = 0; i < 3; i++)
      apply(mk(1, 1, 16'(16'hC000 + i), 1, 4'(i), 0, i + 1));
    for (int i = 0; i < 3; i++) begin
      m_axis_tready = 1'b1; aclken = 1'b1; s_axis_tvalid = 1'b0;
      #1;
      check("restart_tlast", 32'(m_axis_tlast), 32'(i == 2));
      apply(mk(1, 0, 16'd0, 0, 4'd0, 1, 2 - i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/acc_result_fifo.md
# acc_result_fifo

Downstream stage of `floating_point_accumulator`, and of its stand-in `dummy_accumulator`. It captures only the final, tlast-marked sums from the accumulator's result stream and discards the partial sums. Captured sums go into a small FIFO. The FIFO drives an AXI-Stream master with backpressure, because the accumulator has no tready and cannot be stalled. The block regroups the sums into frames and reports any sums it loses to overflow.

## Interface
- `DATA_WIDTH`, 16, width of each sum word (fp16 bit pattern; the block never interprets it).
- `TUSER_WIDTH`, 4, sideband width, carried through unchanged.
- `FIFO_DEPTH`, 4, number of FIFO entries; power of 2, at least 2.
- `GROUPS_PER_FRAME`, 3, output words per frame; `m_axis_tlast` is asserted on the last word of each frame; at least 1.
- `DROP_CNT_WIDTH`, 8, width of the saturating drop counter.

Ports:
- `aclk`  in  1  clock; everything is on the rising edge.
- `aresetn`  in  1  reset, asynchronous, active-low.
- `aclken`  in  1  clock enable; when low all state freezes.
- `s_axis_tvalid`  in  1  accumulator result valid.
- `s_axis_tdata`  in  DATA_WIDTH  accumulator result.
- `s_axis_tlast`  in  1  marks the final sum of a group.
- `s_axis_tuser`  in  TUSER_WIDTH  sideband of the result.
- `m_axis_tvalid`  out  1  FIFO head valid.
- `m_axis_tready`  in  1  consumer ready.
- `m_axis_tdata`  out  DATA_WIDTH  FIFO head data.
- `m_axis_tuser`  out  TUSER_WIDTH  FIFO head sideband.
- `m_axis_tlast`  out  1  last word of an output frame.
- `fill_level`  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.
- `overflow`  out  1  sticky; set once any sum has been dropped.
- `drop_count`  out  DROP_CNT_WIDTH  number of dropped sums, saturating.

## Operation
- **Capture:** `cap = aclken & s_axis_tvalid & s_axis_tlast`. Beats with tvalid high and tlast low are partial sums and are ignored.
- **Pop:** `pop = aclken & m_axis_tvalid & m_axis_tready`.
- **Push:** `push = cap & (fill_level < FIFO_DEPTH | pop)`.
  - Capture into a full FIFO while a pop happens in the same cycle is accepted.
  - Capture into a full FIFO with no pop is dropped.
- **Drop:** `drop = cap & ~push`.
  - `overflow` is set to 1 and stays set until reset.
  - `drop_count` increments and saturates at all-ones.
- **Storage:** circular buffer with `wr_ptr`/`rd_ptr` of $clog2(FIFO_DEPTH) bits, wrapping modulo FIFO_DEPTH.
  - `fill_level` is +1 on push only, -1 on pop only, unchanged on both or neither.
- **Outputs:**
  - `m_axis_tvalid = (fill_level != 0)`.
  - `m_axis_tdata`/`m_axis_tuser` present the entry at `rd_ptr`.
  - Head data is stable while tvalid is high and tready is low.
- **Frame counter:** `frm_cnt`, range 0..GROUPS_PER_FRAME-1.
  - Increments on pop and wraps to 0 after GROUPS_PER_FRAME-1.
  - `m_axis_tlast = m_axis_tvalid & (frm_cnt == GROUPS_PER_FRAME-1)`.
  - With GROUPS_PER_FRAME = 1, every output word carries tlast.
- **aclken low:** no push, pop or drop occurs, and no counter moves. Outputs hold their values; tready is ignored that cycle.
- **Reset (asynchronous assertion):** pointers, `fill_level`, `frm_cnt`, `overflow` and `drop_count` all go to 0. `m_axis_tvalid` and `m_axis_tlast` go to 0 and `m_axis_tdata`/`m_axis_tuser` read 0. FIFO contents are discarded.
  - Reset mid-frame restarts framing at word 0.
  - Inputs are ignored on the first edge after reset deassertion only if synchroniser timing requires it. Otherwise capture is legal from the first enabled edge.

## Timing
- Capture latency is 1 cycle: a capture at edge N into an empty FIFO raises `m_axis_tvalid` after edge N. There is no combinational path from s_axis to m_axis.
- Throughput is 1 word/cycle, with simultaneous push and pop, including at full and at empty (a pop at fill 1 together with a push keeps tvalid high).
- `fill_level`, `overflow` and `drop_count` are registered and update after the edge on which the event occurs.
- All outputs are registered, or decoded only from registered state; `m_axis_tready` does not reach any output combinationally.

## Test plan
1. **Basic path:** drive sums 15360, 16384 (tlast 0) then 17408 (tlast 1, tuser 4'd5), tready 1.
   - Exactly one output word: tdata 17408, tuser 5.
   - tvalid rises 1 cycle after capture; `fill_level` returns to 0.
2. **Backpressure and framing:** tready 0, capture 3 tlast sums 18432, 18944, 19328.
   - fill_level reaches 3.
   - Raise tready: words emerge in order on 3 consecutive cycles, tlast only on 19328.
3. **Overflow:** tready 0, FIFO_DEPTH 4, capture 6 tlast sums.
   - fill_level saturates at 4; overflow is 1; drop_count is 2.
   - The output drains the first 4 sums only.
4. **Full with pop:** FIFO full, tready 1, capture a new sum in the same cycle.
   - No drop; fill_level stays 4; the new sum appears after the older 4.
5. **Clock enable and reset:** aclken 0 for 3 cycles with tvalid/tlast/tready all high.
   - No state change.
   - Then assert aresetn low mid-frame: every output reads 0 immediately, and the next frame's tlast lands on the 3rd word after restart.
